v6502_sim_mem: RTL

//   Parametrised simulation memory subsystem for the 6502 core under Verilator.

---
 rtl/v6502_sim_mem.sv | 137 +++++++++++++
 1 files changed

// File: rtl/v6502_sim_mem.sv
// Simulation memory for the 6502 core: byte RAM (`mem`, preloaded hierarchically by the
// harness image loader), RDY wait states, ROM write protection and a small I/O page.
module v6502_sim_mem #(
  parameter int                ADDR_W      = 16,
  parameter int                WAIT_STATES = 1,
  parameter bit                POISON      = 1'b1,
  parameter bit                ROM_EN      = 1'b1,
  parameter logic [ADDR_W-1:0] ROM_BASE    = 'hE000,
  parameter logic [7:0]        IO_PAGE     = 8'hBF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        cpu_do,
  input  logic              cpu_we,
  output logic [7:0]        cpu_di,
  output logic              rdy,
  output logic              irq,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              done,
  output logic [7:0]        exit_code,
  output logic              wr_fault
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  logic [7:0]  mem [2**ADDR_W];
  logic [2:0]  wcnt;
  logic [7:0]  rd_q;
  logic [15:0] cycle_cnt;
  logic [7:0]  shadow;
  logic [15:0] reload;
  logic [15:0] count;
  logic        tmr_en;
  logic        irq_en;
  logic        pending;

  logic        wr;
  logic        rd;
  logic        io_sel;
  logic        rom_sel;
  logic [7:0]  io_off;
  logic [7:0]  io_rdata;
  logic        ctrl_wr;
  logic        tick;
  logic        tmr_set;
  logic        tmr_clr;

  assign rdy     = (wcnt == 3'd0);
  assign wr      = rdy & cpu_we;
  assign rd      = rdy & ~cpu_we;
  assign io_sel  = (addr[ADDR_W-1 -: 8] == IO_PAGE);
  assign rom_sel = ROM_EN && (addr >= ROM_BASE);
  assign io_off  = addr[7:0];
  assign ctrl_wr = wr & io_sel & (io_off == 8'h06);
  assign tick    = rdy & tmr_en;
  assign tmr_set = tick & (count == 16'd0);
  assign tmr_clr = ctrl_wr & cpu_do[7];

  assign cpu_di = (POISON && !rdy) ? 8'hAA : rd_q;
  assign irq    = pending & irq_en;

  always_comb begin
    io_rdata = 8'h00;
    case (io_off)
      8'h02:   io_rdata = cycle_cnt[7:0];
      8'h03:   io_rdata = shadow;
      8'h04:   io_rdata = reload[7:0];
      8'h05:   io_rdata = reload[15:8];
      8'h06:   io_rdata = {pending, 5'b0, irq_en, tmr_en};
      default: io_rdata = 8'h00;
    endcase
  end

  // RAM contents deliberately survive reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && wr && !io_sel && !rom_sel) mem[addr] <= cpu_do;
  end

  always_ff @(posedge clk) begin
    if (rst)     rd_q <= 8'h00;
    else if (rd) rd_q <= io_sel ? io_rdata : mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt      <= 3'd0;
      cycle_cnt <= 16'd0;
    end else begin
      wcnt      <= (wcnt == WS) ? 3'd0 : 3'(wcnt + 3'd1);
      cycle_cnt <= cycle_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      done      <= 1'b0;
      exit_code <= 8'h00;
      wr_fault  <= 1'b0;
      shadow    <= 8'h00;
      reload    <= 16'd0;
      count     <= 16'd0;
      tmr_en    <= 1'b0;
      irq_en    <= 1'b0;
      pending   <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      wr_fault <= wr & rom_sel & ~io_sel;
      if (wr && io_sel) begin
        case (io_off)
          8'h00: begin
            tx_data  <= cpu_do;
            tx_valid <= 1'b1;
          end
          8'h01: begin
            exit_code <= cpu_do;
            done      <= 1'b1;
          end
          8'h04:   reload[7:0]      <= cpu_do;
          8'h05:   reload[15:8]     <= cpu_do;
          8'h06:   {irq_en, tmr_en} <= cpu_do[1:0];
          default: ;
        endcase
      end
      if (rd && io_sel && io_off == 8'h02) shadow <= cycle_cnt[15:8];
      // Enable edge loads the counter; a reload written mid-count waits for the wrap.
      if (ctrl_wr && cpu_do[0] && !tmr_en) count <= reload;
      else if (tick)                       count <= (count == 16'd0) ? reload : count - 16'd1;
      if (tmr_set)      pending <= 1'b1;
      else if (tmr_clr) pending <= 1'b0;
    end
  end

endmodule
